quat_mult_seq: RTL and testbench

QUAT_MULT_SEQ -- requirements
Module: quat_mult_seq

---
 rtl/quat_mult_seq.sv | 122 ++++++++++++
 tb/tb_quat_mult_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/quat_mult_seq.sv
// Sequential quaternion multiplier: Q1*Q2 computed with a single 16x16 signed
// multiplier over 16 cycles. The four 32-bit accumulators drive r1..r4
// directly and hold the finished product until the consumer takes it.
module quat_mult_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic [15:0] c1,
   input  logic [15:0] d1,
   input  logic [15:0] a2,
   input  logic [15:0] b2,
   input  logic [15:0] c2,
   input  logic [15:0] d2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] r1,
   output logic [31:0] r2,
   output logic [31:0] r3,
   output logic [31:0] r4,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   // One bit per step: 1 = subtract the product at that step.
   // The steps that subtract are 1, 2, 3, 7, 9 and 14.
   localparam logic [15:0] SUB_MASK = 16'h428E;

   state_t             state_q, state_d;
   logic [3:0]         step_q;
   logic signed [15:0] q1_q [4];   // a1, b1, c1, d1
   logic signed [15:0] q2_q [4];   // a2, b2, c2, d2
   logic [31:0]        acc_q [4];  // r1, r2, r3, r4

   logic               accept;
   logic [1:0]         x_sel, y_sel;
   logic               sub;
   logic signed [31:0] prod;
   logic [31:0]        term;

   assign accept = in_valid && in_ready;

   // Step decode: Q1 component cycles a,b,c,d inside each group of four, and
   // the Q2 component is that index XORed with the group number, which
   // reproduces the Hamilton product term ordering.
   assign x_sel = step_q[1:0];
   assign y_sel = step_q[1:0] ^ step_q[3:2];
   assign sub   = SUB_MASK[step_q];
   assign prod  = q1_q[x_sel] * q2_q[y_sel];
   assign term  = sub ? (~prod + 32'd1) : prod;

   // State register
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)        state_d = MUL;
         MUL:     if (step_q == 4'd15) state_d = DONE;
         DONE:    if (out_ready)       state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         IDLE:    in_ready  = 1'b1;
         MUL:     busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Operand latch, accumulator clear on accept, one multiply-accumulate per MUL cycle
   // NOTE: operand and accumulator arrays are reset explicitly because an
   // abandoned result must read as zero immediately on reset, not stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q <= '0;
         for (int i = 0; i < 4; i++) begin
            q1_q[i]  <= '0;
            q2_q[i]  <= '0;
            acc_q[i] <= '0;
         end
      end else if (accept) begin
         step_q  <= '0;
         q1_q[0] <= a1;
         q1_q[1] <= b1;
         q1_q[2] <= c1;
         q1_q[3] <= d1;
         q2_q[0] <= a2;
         q2_q[1] <= b2;
         q2_q[2] <= c2;
         q2_q[3] <= d2;
         for (int i = 0; i < 4; i++) acc_q[i] <= '0;
      end else if (state_q == MUL) begin
         acc_q[step_q[3:2]] <= acc_q[step_q[3:2]] + term;
         step_q             <= step_q + 4'd1;
      end
   end

   assign r1 = acc_q[0];
   assign r2 = acc_q[1];
   assign r3 = acc_q[2];
   assign r4 = acc_q[3];

endmodule

// File: tb/tb_quat_mult_seq.sv
// Self-checking bench for quat_mult_seq: directed product vectors plus random
// operands checked against a plain-arithmetic Hamilton product model.
module tb_quat_mult_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [15:0] a1, b1, c1, d1, a2, b2, c2, d2;
   logic        out_valid, out_ready;
   logic [31:0] r1, r2, r3, r4;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   quat_mult_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a1        (a1),
      .b1        (b1),
      .c1        (c1),
      .d1        (d1),
      .a2        (a2),
      .b2        (b2),
      .c2        (c2),
      .d2        (d2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .r1        (r1),
      .r2        (r2),
      .r3        (r3),
      .r4        (r4),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: Hamilton product with 32-bit wrapping integer arithmetic.
   function automatic logic [127:0] qmul(input logic [63:0] q1, input logic [63:0] q2);
      int pa, pb, pc, pd, qa, qb, qc, qd;
      int w, x, y, z;
      pa = int'($signed(q1[63:48])); pb = int'($signed(q1[47:32]));
      pc = int'($signed(q1[31:16])); pd = int'($signed(q1[15:0]));
      qa = int'($signed(q2[63:48])); qb = int'($signed(q2[47:32]));
      qc = int'($signed(q2[31:16])); qd = int'($signed(q2[15:0]));
      w = pa*qa - pb*qb - pc*qc - pd*qd;
      x = pa*qb + pb*qa + pc*qd - pd*qc;
      y = pa*qc - pb*qd + pc*qa + pd*qb;
      z = pa*qd + pb*qc - pc*qb + pd*qa;
      return {w, x, y, z};
   endfunction

   task automatic drive_ops(input logic [63:0] q1, input logic [63:0] q2);
      {a1, b1, c1, d1} = q1;
      {a2, b2, c2, d2} = q2;
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // One full transaction: accept, 16 MUL cycles, optional DONE stall, handshake.
   task automatic run_op(input logic [63:0] q1, input logic [63:0] q2,
                         input logic [127:0] exp, input int stall, input bit toggle);
      int lat;
      logic [127:0] held;
      @(negedge clk);
      drive_ops(q1, q2);
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      check("in_ready_idle", {31'd0, in_ready}, 32'd1);
      @(negedge clk);                       // just after the accept edge
      in_valid = 1'b0;
      check("busy_mul", {31'd0, busy}, 32'd1);
      check("in_ready_mul", {31'd0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         if (toggle) begin
            drive_ops(rnd64(), rnd64());
            in_valid = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check("latency", lat, 32'd16);
      check("r1", r1, exp[127:96]);
      check("r2", r2, exp[95:64]);
      check("r3", r3, exp[63:32]);
      check("r4", r4, exp[31:0]);
      check("busy_done", {31'd0, busy}, 32'd0);
      held = {r1, r2, r3, r4};
      for (int s = 0; s < stall; s++) begin
         drive_ops(rnd64(), rnd64());
         in_valid = 1'b1;
         @(negedge clk);
         check("bp_valid", {31'd0, out_valid}, 32'd1);
         check("bp_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_r1r2", r1 ^ r2, held[127:96] ^ held[95:64]);
         check("bp_hold_r3", r3, held[63:32]);
         check("bp_hold_r4", r4, held[31:0]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("valid_dropped", {31'd0, out_valid}, 32'd0);
      check("in_ready_back", {31'd0, in_ready}, 32'd1);
      check("idle_hold_r1", r1, exp[127:96]);
   endtask

   localparam logic [63:0] Q1234 = {16'd1, 16'd2, 16'd3, 16'd4};
   localparam logic [63:0] Q5678 = {16'd5, 16'd6, 16'd7, 16'd8};
   localparam logic [127:0] R_GEN = {32'hFFFFFFC4, 32'd12, 32'd30, 32'd24};

   initial begin
      logic [63:0] q1, q2;
      int seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive_ops(64'd0, 64'd0);
      #2;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_r1", r1, 32'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      run_op(Q1234, Q5678, R_GEN, 0, 1'b0);
      run_op({16'd1, 16'd0, 16'd0, 16'd0}, Q5678, {32'd5, 32'd6, 32'd7, 32'd8}, 0, 1'b0);
      run_op({16'd0, 16'd1, 16'd0, 16'd0}, {16'd0, 16'd1, 16'd0, 16'd0},
             {32'hFFFFFFFF, 32'd0, 32'd0, 32'd0}, 0, 1'b0);
      run_op({4{16'h8000}}, {4{16'h8000}}, {4{32'h80000000}}, 0, 1'b0);
      run_op(Q1234, Q5678, R_GEN, 5, 1'b1);

      // Random operands, operands toggled during MUL, random DONE stalls
      for (int n = 0; n < 12; n++) begin
         q1 = rnd64();
         q2 = rnd64();
         run_op(q1, q2, qmul(q1, q2), $urandom_range(0, 3), 1'b1);
      end

      // Reset in the middle of MUL at step 8
      @(negedge clk);
      drive_ops(rnd64(), rnd64());
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_r1", r1, 32'd0);
      check("mid_rst_r2", r2, 32'd0);
      check("mid_rst_r3", r3, 32'd0);
      check("mid_rst_r4", r4, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("no_valid_after_rst", seen, 32'd0);
      run_op(Q1234, Q5678, R_GEN, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
